// File: rtl/neuron_bit_serializer.sv
// Parallel-to-bit-serial neuron converter feeding serial_ip_pipe.
// An active group streams MSB-first over its precision while a one-entry shadow holds the next.
module neuron_bit_serializer #(
   parameter int unsigned N  = 16,
   parameter int unsigned Ti = 16,
   parameter int unsigned PW = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [Ti*N-1:0] i_neurons,
   input  logic [PW-1:0]   i_precision,
   input  logic            i_stall,
   output logic            o_valid,
   output logic [Ti-1:0]   o_bits,
   output logic            o_first_cycle,
   output logic            o_last_cycle,
   output logic [PW-1:0]   o_precision
);

   localparam int unsigned IW = $clog2(N);

   logic            act_valid;
   logic [Ti*N-1:0] act_data;
   logic [PW-1:0]   act_p;
   logic [PW-1:0]   k;
   logic            shd_full;
   logic [Ti*N-1:0] shd_data;
   logic [PW-1:0]   shd_p;
   logic            ready_en;

   logic [PW-1:0]   in_p;
   logic            finishing;
   logic            act_free;
   logic            accept;
   logic            to_act;
   logic [IW-1:0]   bit_idx;
   logic [N-1:0]    lane;

   always_comb begin
      in_p = i_precision;
      if (i_precision == '0 || i_precision > PW'(N)) begin
         in_p = PW'(N);
      end
      finishing = act_valid && (k == act_p - PW'(1));
      // Active can take new data this edge: idle, or its last slice is leaving now.
      act_free  = !act_valid || (finishing && !i_stall);
      accept    = i_valid && o_ready;
      to_act    = accept && act_free && !shd_full;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         act_valid <= 1'b0;
         act_data  <= '0;
         act_p     <= '0;
         k         <= '0;
         shd_full  <= 1'b0;
         shd_data  <= '0;
         shd_p     <= '0;
         ready_en  <= 1'b0;
      end else begin
         ready_en <= 1'b1;
         if (act_free) begin
            if (shd_full) begin
               act_valid <= 1'b1;
               act_data  <= shd_data;
               act_p     <= shd_p;
               k         <= '0;
            end else if (accept) begin
               act_valid <= 1'b1;
               act_data  <= i_neurons;
               act_p     <= in_p;
               k         <= '0;
            end else begin
               act_valid <= 1'b0;
            end
         end else if (!i_stall) begin
            k <= k + PW'(1);
         end

         if (accept && !to_act) begin
            shd_full <= 1'b1;
            shd_data <= i_neurons;
            shd_p    <= in_p;
         end else if (act_free && shd_full) begin
            shd_full <= 1'b0;
         end
      end
   end

   always_comb begin
      bit_idx = IW'(act_p - k - PW'(1));
      lane    = '0;
      o_bits  = '0;
      if (act_valid) begin
         for (int i = 0; i < int'(Ti); i++) begin
            lane      = act_data[i*N +: N];
            o_bits[i] = lane[bit_idx];
         end
      end
   end

   assign o_ready       = ready_en && !shd_full;
   assign o_valid       = act_valid;
   assign o_first_cycle = act_valid && (k == '0);
   assign o_last_cycle  = finishing;
   assign o_precision   = act_valid ? act_p : '0;

endmodule

// File: tb/tb_neuron_bit_serializer.sv
// Randomized and directed bench for neuron_bit_serializer against a queue-of-groups model.
module tb_neuron_bit_serializer;

   localparam int N  = 16;
   localparam int Ti = 16;
   localparam int PW = 5;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            i_valid = 1'b0;
   logic            o_ready;
   logic [Ti*N-1:0] i_neurons = '0;
   logic [PW-1:0]   i_precision = '0;
   logic            i_stall = 1'b0;
   logic            o_valid;
   logic [Ti-1:0]   o_bits;
   logic            o_first_cycle;
   logic            o_last_cycle;
   logic [PW-1:0]   o_precision;

   neuron_bit_serializer #(.N(N), .Ti(Ti), .PW(PW)) dut (
      .clk          (clk),
      .reset        (reset),
      .i_valid      (i_valid),
      .o_ready      (o_ready),
      .i_neurons    (i_neurons),
      .i_precision  (i_precision),
      .i_stall      (i_stall),
      .o_valid      (o_valid),
      .o_bits       (o_bits),
      .o_first_cycle(o_first_cycle),
      .o_last_cycle (o_last_cycle),
      .o_precision  (o_precision)
   );

   always #5 clk = ~clk;

   // Pending groups in emission order; k counts slices already emitted.
   typedef struct {
      logic [Ti*N-1:0] data;
      int              p;
      int              k;
   } grp_t;

   grp_t q[$];
   int   n_pass = 0;
   int   n_checks = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
   endtask

   function automatic int eff_p(input logic [PW-1:0] pr);
      if (pr == 0 || int'(pr) > N) return N;
      return int'(pr);
   endfunction

   function automatic logic [Ti-1:0] exp_bits(input grp_t g);
      logic [Ti-1:0] r;
      logic [N-1:0]  v;
      for (int i = 0; i < Ti; i++) begin
         v    = g.data[i*N +: N];
         r[i] = v[g.p - 1 - g.k];
      end
      return r;
   endfunction

   task automatic check_outputs();
      check_eq("valid", o_valid, q.size() > 0);
      check_eq("ready", o_ready, q.size() < 2);
      if (q.size() > 0) begin
         check_eq("bits", o_bits, exp_bits(q[0]));
         check_eq("first", o_first_cycle, q[0].k == 0);
         check_eq("last", o_last_cycle, q[0].k == q[0].p - 1);
         check_eq("prec", o_precision, q[0].p);
      end
   endtask

   // One clock: check current outputs, drive inputs, then advance the model at the edge.
   task automatic cycle(input bit v, input logic [Ti*N-1:0] d, input logic [PW-1:0] pr,
                        input bit st);
      bit   acc;
      grp_t g;
      @(negedge clk);
      check_outputs();
      i_valid     = v;
      i_neurons   = d;
      i_precision = pr;
      i_stall     = st;
      acc = v && (q.size() < 2);
      @(posedge clk);
      if (q.size() > 0 && !st) begin
         q[0].k++;
         if (q[0].k == q[0].p) void'(q.pop_front());
      end
      if (acc) begin
         g.data = d;
         g.p    = eff_p(pr);
         g.k    = 0;
         q.push_back(g);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 1'b0);
   endtask

   function automatic logic [Ti*N-1:0] rand_data();
      logic [Ti*N-1:0] r;
      for (int i = 0; i < Ti*N/32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_valid"}, o_valid, 1'b0);
      check_eq({tag, "_bits"}, o_bits, '0);
      check_eq({tag, "_first"}, o_first_cycle, 1'b0);
      check_eq({tag, "_last"}, o_last_cycle, 1'b0);
      check_eq({tag, "_prec"}, o_precision, '0);
      check_eq({tag, "_ready"}, o_ready, 1'b0);
   endtask

   logic [Ti*N-1:0] alt;

   initial begin
      #1;
      check_reset_outputs("rst");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);

      // Single group, 0x000A at p=5 -> 0,1,0,1,0
      cycle(1'b1, {Ti{16'h000A}}, 5'd5, 1'b0);
      idle(7);

      // Back-to-back with i_valid held
      cycle(1'b1, {Ti{16'hFFFF}}, 5'd3, 1'b0);
      cycle(1'b1, {Ti{16'h0005}}, 5'd3, 1'b0);
      idle(8);

      // Stall for 3 cycles while slice index 2 is showing
      cycle(1'b1, {Ti{16'h0013}}, 5'd5, 1'b0);
      cycle(1'b0, '0, '0, 1'b0);
      cycle(1'b0, '0, '0, 1'b0);
      cycle(1'b0, '0, '0, 1'b1);
      cycle(1'b0, '0, '0, 1'b1);
      cycle(1'b0, '0, '0, 1'b1);
      idle(5);

      // Precision edges
      for (int i = 0; i < Ti; i++) alt[i*N +: N] = (i % 2 == 0) ? 16'd1 : 16'd0;
      cycle(1'b1, alt, 5'd1, 1'b0);
      idle(2);
      cycle(1'b1, rand_data(), 5'd0, 1'b0);
      cycle(1'b1, rand_data(), 5'd20, 1'b0);
      idle(36);

      // Reset mid-stream with shadow full
      cycle(1'b1, rand_data(), 5'd8, 1'b0);
      cycle(1'b1, rand_data(), 5'd8, 1'b0);
      cycle(1'b0, '0, '0, 1'b0);
      cycle(1'b0, '0, '0, 1'b0);
      @(negedge clk);
      i_valid = 1'b0;
      reset = 1'b0;
      #1;
      check_reset_outputs("midrst");
      q.delete();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      idle(3);

      // Randomized traffic
      for (int c = 0; c < 2000; c++) begin
         cycle($urandom_range(0, 9) < 6, rand_data(),
               ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31))
                                           : 5'($urandom_range(1, 4)),
               $urandom_range(0, 3) == 0);
      end
      idle(40);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/neuron_bit_serializer.md
# neuron_bit_serializer

Converts groups of Ti parallel N-bit neuron values into the bit-serial neuron stream consumed by serial_ip_pipe: one bit per lane per cycle, MSB-first over a per-group precision p, with first/last-cycle flags. It sits directly upstream of serial_ip_pipe. A one-entry shadow buffer lets consecutive groups stream without bubbles. A downstream stall holds the stream.

## Interface
- N, 16, neuron value width in bits
- Ti, 16, number of neuron lanes
- PW, 5, width of the precision field

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- i_valid  in  1  input group valid
- o_ready  out  1  block can accept a group this cycle
- i_neurons  in  Ti*N  lane i occupies bits [(i+1)*N-1 : i*N]
- i_precision  in  PW  bits to serialize for this group
- i_stall  in  1  downstream hold
- o_valid  out  1  o_bits carries a valid bit-slice
- o_bits  out  Ti  lane i carries the current bit of neuron i
- o_first_cycle  out  1  first bit-slice of a group; drives serial_ip_pipe i_first_cycle
- o_last_cycle  out  1  final bit-slice of a group
- o_precision  out  PW  effective precision of the group being emitted

## Operation
- **Storage:**
  - active register: Ti*N data, p, and bit counter k.
  - shadow register: Ti*N data and p, plus a full flag.
- **Effective precision:** p = i_precision, except i_precision==0 or >N gives p=N. p is latched with the data.
- **Serialization:** at step k (0..p-1), o_bits[i] = neuron_i[p-1-k]. This is MSB-first within p bits. Bits above p-1 are ignored.
- **Active-state machine:**
  - IDLE: o_valid=0.
  - Entering STREAM sets k=0.
  - Each non-stalled cycle in STREAM increments k.
  - At k==p-1 the active group is finishing. On the next edge it reloads from shadow (if full) or from input (if accepted), or returns to IDLE.
- **Acceptance:** occurs when i_valid && o_ready, with o_ready = !shadow_full.
  - Accepted data goes straight to active when active is IDLE, or active is finishing and not stalled, and the shadow is empty.
  - Otherwise accepted data goes to shadow.
- **Simultaneous events:**
  - Shadow full and active finishing: shadow moves to active.
  - Accept while the shadow empties: the new input lands in shadow on the same edge.
- **Stall:** i_stall=1 freezes k, o_bits, o_valid, o_first_cycle, o_last_cycle and o_precision. Acceptance into an empty shadow is still allowed during stall.
- **Flags:**
  - o_first_cycle = o_valid && k==0.
  - o_last_cycle = o_valid && k==p-1.
  - For p=1 both flags are high in the same cycle.

## Timing
- **Reset:** reset low clears to IDLE and shadow empty. Outputs while reset is low: o_valid=0, o_bits=0, o_first_cycle=0, o_last_cycle=0, o_precision=0, o_ready=0. o_ready=1 from the first cycle after release.
- **Latency:** a group accepted at edge E into an idle block gives o_valid=1 with o_first_cycle=1 after E. Its last slice appears p-1 cycles later.
- **Throughput:** back-to-back groups produce no idle cycle. o_first_cycle of group n+1 immediately follows o_last_cycle of group n.
- **o_ready:** deasserts the cycle after a group lands in shadow. It reasserts the cycle after shadow drains.
- **Outputs:** all outputs are registered or derived from registered state only. There is no combinational path from i_valid or i_neurons to o_bits.
- **Reset mid-stream:** the in-flight group and shadow contents are discarded. No partial last-cycle pulse is emitted.
- **Input hold:** i_neurons and i_precision need only be stable in the accept cycle.

## Test plan
- **Single group:** all lanes 10 (0x000A), p=5, accepted at edge 1.
  - o_bits per lane over 5 cycles: 0,1,0,1,0.
  - o_first_cycle in cycle 1 only; o_last_cycle in cycle 5 only; o_valid low afterwards.
  - Feeding serial_ip_pipe with synapse 37 yields 370 after the last slice.
- **Back-to-back:** group A=0xFFFF (p=3) then group B=0x0005 (p=3), i_valid held.
  - Output stream: 1,1,1 then 1,0,1 with no gap.
  - o_ready drops for exactly the cycles shadow is full.
- **Stall:** all lanes 0x0013, p=5, i_stall high for 3 cycles after slice 2.
  - Slice 2 is held for 4 total cycles.
  - Full sequence 1,0,0,1,1 is preserved; o_last_cycle fires once.
- **Precision edges:**
  - p=1 with lanes alternating 1/0: single slice with first=last=1, o_bits=0x5555.
  - i_precision=0 or 20: 16 slices, o_precision=16.
- **Reset mid-operation:** assert reset at slice 3 of a p=8 group with shadow full.
  - Outputs go to 0 asynchronously.
  - After release: IDLE, o_ready=1, no residual o_valid.
